// File: rtl/ram_bus_pkg.sv
// Shared constants and helpers for the two-port RAM bus arbiter.
package ram_bus_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t SETUP   = 2'd1;
   localparam state_t STROBE  = 2'd2;
   localparam state_t RECOVER = 2'd3;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   function automatic logic other_port(input logic p);
      return (p == PORT0) ? PORT1 : PORT0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the port not granted last wins.
module rr_arbiter2
   import ram_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant,
   output logic       valid
);

   // Port holding priority for the next tie; port0 first after reset.
   logic prio;

   always_comb begin
      valid = |req;
      grant = PORT0;
      case (req)
         2'b01:   grant = PORT0;
         2'b10:   grant = PORT1;
         2'b11:   grant = prio;
         default: grant = PORT0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio <= PORT0;
      end else if (advance) begin
         prio <= other_port(grant);
      end
   end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Sequences single RAM bus accesses (setup / strobe / recover) for two requesters.
module ram_bus_arbiter
   import ram_bus_pkg::*;
#(
   parameter int STROBE_CYCLES = 1,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF
) (
   input  logic              bclk,
   input  logic              brst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ABus,
   output logic [DATA_W-1:0] dbus_out,
   output logic              dbus_oe,
   input  logic [DATA_W-1:0] dbus_in,
   output logic              bnRD,
   output logic              bnWR
);

   localparam logic [1:0] CNT_LAST = 2'(STROBE_CYCLES - 1);

   state_t            state;
   logic [1:0]        cnt;
   logic              cur_port;
   logic              cur_we;

   logic              win_port;
   logic              win_valid;
   logic              advance;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign advance = (state == IDLE) && win_valid;

   rr_arbiter2 u_arb (
      .clk     (bclk),
      .rst     (brst),
      .req     ({req1, req0}),
      .advance (advance),
      .grant   (win_port),
      .valid   (win_valid)
   );

   always_comb begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
      if (win_port == PORT1) begin
         sel_we    = we1;
         sel_addr  = addr1;
         sel_wdata = wdata1;
      end
   end

   // ABus/dbus_out double as the address/data latches and stay put until the next accept.
   always_ff @(posedge bclk or posedge brst) begin
      if (brst) begin
         state    <= IDLE;
         cnt      <= 2'd0;
         cur_port <= PORT0;
         cur_we   <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         rdata    <= '0;
         ABus     <= '0;
         dbus_out <= '0;
         dbus_oe  <= 1'b0;
         bnRD     <= 1'b1;
         bnWR     <= 1'b1;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  state    <= SETUP;
                  cur_port <= win_port;
                  cur_we   <= sel_we;
                  ABus     <= sel_addr;
                  gnt0     <= (win_port == PORT0);
                  gnt1     <= (win_port == PORT1);
                  if (sel_we) begin
                     dbus_out <= sel_wdata;
                     dbus_oe  <= 1'b1;
                  end
               end
            end
            SETUP: begin
               state <= STROBE;
               cnt   <= 2'd0;
               if (cur_we) begin
                  bnWR <= 1'b0;
               end else begin
                  bnRD <= 1'b0;
               end
            end
            STROBE: begin
               if (cnt == CNT_LAST) begin
                  state <= RECOVER;
                  cnt   <= 2'd0;
                  bnRD  <= 1'b1;
                  bnWR  <= 1'b1;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            RECOVER: begin
               // Write data stays driven through this cycle for RAM hold time.
               state   <= IDLE;
               dbus_oe <= 1'b0;
               done0   <= (cur_port == PORT0);
               done1   <= (cur_port == PORT1);
               if (!cur_we) begin
                  rdata <= dbus_in;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
